// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron datapath blocks.
// The spike event format is fixed here so every consumer agrees on its layout.
package snn_pkg;

  localparam int N_DEF     = 32;
  localparam int Q_DEF     = 16;
  localparam int TS_W_DEF  = 16;
  localparam int ISI_W_DEF = 12;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [TS_W_DEF-1:0]  timestamp;
    logic [ISI_W_DEF-1:0] isi;
  } spike_event_t;

  // All-ones ISI means "no previous spike since reset".
  localparam logic [ISI_W_DEF-1:0] ISI_NONE = '1;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX  = '1;

endpackage

// File: rtl/fixed_point_cmp.sv
// Signed two's-complement fixed-point magnitude compare, shared with the neuron core.
// Fractional position is irrelevant to ordering, so only the word width is a parameter.
module fixed_point_cmp #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq,
  output logic         gt
);

  assign eq = (a == b);
  assign gt = ($signed(a) > $signed(b));

endmodule

// File: rtl/spike_fifo.sv
// Synchronous FIFO of spike events; extra pointer MSB separates full from empty.
// The head entry is presented combinationally from stored state and reads zero when empty.
module spike_fifo
  import snn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  spike_event_t wr_data,
  input  logic         pop,
  output spike_event_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  spike_event_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/izhikevich_spike_encoder.sv
// Turns membrane-voltage threshold crossings into timestamped spike events with ISI,
// queues them for a valid/ready consumer and keeps spike/drop statistics.
module izhikevich_spike_encoder
  import snn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int ISI_W = ISI_W_DEF,
  parameter int DEPTH = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             apply,
  input  logic [N-1:0]     voltage,
  input  logic [N-1:0]     v_th,
  input  logic             clear_stats,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TS_W-1:0]  out_timestamp,
  output logic [ISI_W-1:0] out_isi,
  output logic             spike,
  output logic [CNT_W-1:0] spike_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  // The event layout comes from snn_pkg, so the width parameters must agree with it.
  if (TS_W != TS_W_DEF || ISI_W != ISI_W_DEF || CNT_W != CNT_W_DEF ||
      Q >= N || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("izhikevich_spike_encoder: unsupported parameter combination");
  end

  logic         cmp_eq;
  logic         cmp_gt;
  logic         hit;
  logic         pop;
  logic         push;
  logic         drop;
  logic         fifo_full;
  logic         fifo_empty;
  spike_event_t head;
  spike_event_t new_event;

  logic [TS_W_DEF-1:0]  ts;
  logic [ISI_W_DEF-1:0] isi_cnt;

  fixed_point_cmp #(.N(N)) u_cmp (
    .a  (voltage),
    .b  (v_th),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  assign hit  = apply & (cmp_eq | cmp_gt);
  assign pop  = ~fifo_empty & out_ready;
  assign drop = hit & fifo_full & ~pop;
  assign push = hit & ~drop;

  assign new_event.timestamp = ts;
  assign new_event.isi       = isi_cnt;

  spike_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (new_event),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid     = ~fifo_empty;
  assign out_timestamp = head.timestamp;
  assign out_isi       = head.isi;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts          <= '0;
      isi_cnt     <= ISI_NONE;
      spike       <= 1'b0;
      spike_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      spike <= hit;

      if (apply) ts <= ts + 1'b1;

      if (hit) begin
        isi_cnt <= ISI_W_DEF'(1);
      end else if (apply && isi_cnt != ISI_NONE) begin
        isi_cnt <= isi_cnt + 1'b1;
      end

      // Clearing wins over a same-cycle increment.
      if (clear_stats) begin
        spike_count <= '0;
        drop_count  <= '0;
        overflow    <= 1'b0;
      end else begin
        if (hit && spike_count != CNT_MAX) spike_count <= spike_count + 1'b1;
        if (drop && drop_count != CNT_MAX) drop_count <= drop_count + 1'b1;
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_izhikevich_spike_encoder.sv
// Directed bench for izhikevich_spike_encoder: a vector table for the basic
// detect/stream behaviour plus hand sequences for ISI, overflow, wrap and reset.
module tb_izhikevich_spike_encoder;
  import snn_pkg::*;

  localparam logic [31:0] V_TH  = 32'h001E0000;
  localparam logic [31:0] V_HI  = 32'h001F0000;
  localparam logic [31:0] V_LO  = 32'h001DFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        apply;
  logic [31:0] voltage;
  logic [31:0] v_th;
  logic        clear_stats;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_timestamp;
  logic [11:0] out_isi;
  logic        spike;
  logic [15:0] spike_count;
  logic [15:0] drop_count;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  izhikevich_spike_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .apply         (apply),
    .voltage       (voltage),
    .v_th          (v_th),
    .clear_stats   (clear_stats),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_timestamp (out_timestamp),
    .out_isi       (out_isi),
    .spike         (spike),
    .spike_count   (spike_count),
    .drop_count    (drop_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        apply;
    logic [31:0] voltage;
    logic        ready;
    logic        clear;
    logic        e_spike;
    logic        e_valid;
    logic [15:0] e_ts;
    logic [11:0] e_isi;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; apply = 1'b0; voltage = '0; out_ready = 1'b0; clear_stats = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] drain_ts [8];

  initial begin
    v_th = V_TH;
    //                 apply voltage        rdy clr  spk vld ts     isi      cnt
    vecs[0] = '{1'b1, V_HI,         1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 12'hFFF, 16'd1};
    vecs[1] = '{1'b1, 32'h001E0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 12'd1,   16'd2};
    vecs[2] = '{1'b1, V_LO,         1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 12'd0,   16'd2};
    vecs[3] = '{1'b0, V_HI,         1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 12'd0,   16'd2};
    vecs[4] = '{1'b1, V_HI,         1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 12'd2,   16'd3};
    vecs[5] = '{1'b1, 32'hFFF00000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 12'd0,   16'd3};
    vecs[6] = '{1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5, 12'd2,   16'd4};
    vecs[7] = '{1'b0, V_LO,         1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 12'd2,   16'd4};
    vecs[8] = '{1'b0, V_LO,         1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 12'd2,   16'd0};

    // Reset state
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_count", 32'(spike_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ts", 32'(out_timestamp), 32'd0);
    chk("rst_isi", 32'(out_isi), 32'd0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      apply = vecs[i].apply; voltage = vecs[i].voltage;
      out_ready = vecs[i].ready; clear_stats = vecs[i].clear;
      tick();
      chk($sformatf("vec%0d_spike", i), 32'(spike), 32'(vecs[i].e_spike));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_count", i), 32'(spike_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_ts", i), 32'(out_timestamp), 32'(vecs[i].e_ts));
        chk($sformatf("vec%0d_isi", i), 32'(out_isi), 32'(vecs[i].e_isi));
      end
    end
    apply = 1'b0; clear_stats = 1'b0;

    // ISI between spikes on steps 3 and 10
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s <= 10; s++) begin
      apply = 1'b1;
      voltage = (s == 3 || s == 10) ? V_HI : V_LO;
      tick();
      if (s == 3) begin
        chk("isi_first_ts", 32'(out_timestamp), 32'd3);
        chk("isi_first_isi", 32'(out_isi), 32'(ISI_NONE));
      end
      if (s == 10) begin
        chk("isi_second_ts", 32'(out_timestamp), 32'd10);
        chk("isi_second_isi", 32'(out_isi), 32'd7);
      end
    end
    apply = 1'b0;

    // Overflow: nine spikes into an eight-entry FIFO without reads
    do_reset();
    out_ready = 1'b0;
    voltage = V_HI;
    for (int s = 0; s < 9; s++) begin
      apply = 1'b1;
      tick();
    end
    chk("ovf_spike", 32'(spike), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(spike_count), 32'd9);
    chk("ovf_head_ts", 32'(out_timestamp), 32'd0);
    chk("ovf_head_isi", 32'(out_isi), 32'(ISI_NONE));

    // Full FIFO, push and pop together: no drop
    out_ready = 1'b1;
    tick();
    chk("full_pp_drop", 32'(drop_count), 32'd1);
    chk("full_pp_valid", 32'(out_valid), 32'd1);
    chk("full_pp_count", 32'(spike_count), 32'd10);

    // Backpressure: head must hold
    apply = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ts", 32'(out_timestamp), 32'd1);
      chk("bp_isi", 32'(out_isi), 32'd1);
    end

    // Drain: ts 1..7 then 9 (ts 8 was dropped), occupancy stayed at 8
    for (int i = 0; i < 7; i++) drain_ts[i] = 16'(i + 1);
    drain_ts[7] = 16'd9;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_ts", i), 32'(out_timestamp), 32'(drain_ts[i]));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);

    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr_drop", 32'(drop_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_count", 32'(spike_count), 32'd0);

    // Timestamp wrap and ISI saturation
    do_reset();
    out_ready = 1'b1;
    apply = 1'b1;
    voltage = V_LO;
    repeat (65535) tick();
    voltage = V_HI;
    tick();
    chk("wrap_last_ts", 32'(out_timestamp), 32'hFFFF);
    chk("wrap_last_isi", 32'(out_isi), 32'(ISI_NONE));
    tick();
    chk("wrap_zero_ts", 32'(out_timestamp), 32'd0);
    chk("wrap_zero_isi", 32'(out_isi), 32'd1);

    // Clear with same-cycle hit
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clrhit_spike", 32'(spike), 32'd1);
    chk("clrhit_count", 32'(spike_count), 32'd0);
    apply = 1'b0;

    // Reset mid-operation with three queued events
    do_reset();
    out_ready = 1'b0;
    voltage = V_HI;
    apply = 1'b1;
    repeat (3) tick();
    chk("midrst_queued", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_spike", 32'(spike), 32'd0);
    rst = 1'b0;
    apply = 1'b0;
    tick();
    chk("postrst_valid", 32'(out_valid), 32'd0);
    chk("postrst_count", 32'(spike_count), 32'd0);
    apply = 1'b1;
    tick();
    apply = 1'b0;
    chk("postrst_ts", 32'(out_timestamp), 32'd0);
    chk("postrst_isi", 32'(out_isi), 32'(ISI_NONE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
